// File: rtl/cmos_capture_16b_if.sv
// cmos_capture_16b_if: sensor-side inputs and 16-bit pixel stream of the CMOS capture block.
// Rev 1.0
`default_nettype none

interface cmos_capture_16b_if;
  logic        capture_start;
  logic        cmos_vsync;
  logic        cmos_href;
  logic [7:0]  cmos_data;
  logic [15:0] data_16b;
  logic        data_16b_en;
  logic        cmos_data_valid;
  logic        cap_busy;
  logic        cap_err;

  // Sensor / controller side: drives sync, data and the start pulse.
  modport master (
    output capture_start, cmos_vsync, cmos_href, cmos_data,
    input  data_16b, data_16b_en, cmos_data_valid, cap_busy, cap_err
  );

  // Capture block side.
  modport slave (
    input  capture_start, cmos_vsync, cmos_href, cmos_data,
    output data_16b, data_16b_en, cmos_data_valid, cap_busy, cap_err
  );
endinterface

`default_nettype wire

// File: rtl/cmos_capture_16b.sv
// cmos_capture_16b: single-frame 8-bit CMOS to 16-bit word capture; CAPTURE_TEST_PATTERN_EN swaps pixels for {line,word}.
// Rev 1.0
`default_nettype none

module cmos_capture_16b #(
  parameter int IMG_ROW     = 8,
  parameter int IMG_COL     = 512,
  parameter int SKIP_FRAMES = 2
) (
  input  wire logic         cmos_pclk,
  input  wire logic         rst,
  cmos_capture_16b_if.slave bus
);

  localparam int WW = $clog2(IMG_COL) + 1;
  localparam int LW = $clog2(IMG_ROW) + 1;
  localparam logic [WW-1:0] COLS      = WW'(IMG_COL);
  localparam logic [LW-1:0] LAST_ROW  = LW'(IMG_ROW - 1);
  localparam logic [7:0]    SKIP_INIT = 8'(SKIP_FRAMES);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SKIP    = 3'd1,
    ST_WAIT    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  state_t state, state_nx;

  logic          vs_r, vs_r2, hr_r, hr_r2;
  logic [7:0]    d_r;
  logic [7:0]    skip_cnt;
  logic [LW-1:0] line_cnt;
  logic [WW-1:0] word_cnt;
  logic          byte_ph;
  logic [7:0]    byte0;
  logic [15:0]   data_q;
  logic          en_q;
  logic          valid_q;
  logic          err_q;

  logic          vs_rise, vs_fall, hr_fall;
  logic          word_room;
  logic [15:0]   word_nx;

  assign vs_rise   = vs_r & ~vs_r2;
  assign vs_fall   = ~vs_r & vs_r2;
  assign hr_fall   = ~hr_r & hr_r2;
  assign word_room = (word_cnt < COLS);

`ifdef CAPTURE_TEST_PATTERN_EN
  logic unused_pixel_bytes;
  assign unused_pixel_bytes = ^{byte0, d_r};
  assign word_nx = {8'(line_cnt), 8'(word_cnt)};
`else
  assign word_nx = {byte0, d_r};
`endif

  always_ff @(posedge cmos_pclk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (bus.capture_start) begin
          state_nx = (SKIP_INIT == 8'd0) ? ST_WAIT : ST_SKIP;
        end
      end
      ST_SKIP: begin
        // The pulse that arrives once the count is exhausted is the frame to capture.
        if (vs_rise && (skip_cnt == 8'd0)) begin
          state_nx = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (vs_fall) begin
          state_nx = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (vs_rise) begin
          state_nx = ST_DONE;
        end else if (hr_fall && (line_cnt == LAST_ROW)) begin
          state_nx = ST_DONE;
        end
      end
      ST_DONE: begin
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge cmos_pclk) begin
    if (rst) begin
      vs_r     <= 1'b0;
      vs_r2    <= 1'b0;
      hr_r     <= 1'b0;
      hr_r2    <= 1'b0;
      d_r      <= 8'd0;
      skip_cnt <= 8'd0;
      line_cnt <= '0;
      word_cnt <= '0;
      byte_ph  <= 1'b0;
      byte0    <= 8'd0;
      data_q   <= 16'd0;
      en_q     <= 1'b0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      vs_r  <= bus.cmos_vsync;
      vs_r2 <= vs_r;
      hr_r  <= bus.cmos_href;
      hr_r2 <= hr_r;
      d_r   <= bus.cmos_data;
      en_q  <= 1'b0;
      // Lags the state by one so the window closes two cycles after the last strobe.
      valid_q <= (state == ST_CAPTURE);

      case (state)
        ST_IDLE: begin
          if (bus.capture_start) begin
            err_q    <= 1'b0;
            skip_cnt <= SKIP_INIT;
          end
        end
        ST_SKIP: begin
          if (vs_rise && (skip_cnt != 8'd0)) begin
            skip_cnt <= skip_cnt - 8'd1;
          end
        end
        ST_WAIT: begin
          if (vs_fall) begin
            line_cnt <= '0;
            word_cnt <= '0;
            byte_ph  <= 1'b0;
          end
        end
        ST_CAPTURE: begin
          if (vs_rise) begin
            err_q <= 1'b1;
          end else if (hr_fall) begin
            if ((word_cnt != COLS) || byte_ph) begin
              err_q <= 1'b1;
            end
            line_cnt <= line_cnt + 1'b1;
            word_cnt <= '0;
            byte_ph  <= 1'b0;
          end else if (hr_r) begin
            byte_ph <= ~byte_ph;
            if (!byte_ph) begin
              byte0 <= d_r;
            end else if (word_room) begin
              data_q   <= word_nx;
              en_q     <= 1'b1;
              word_cnt <= word_cnt + 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.data_16b        = data_q;
  assign bus.data_16b_en     = en_q;
  assign bus.cmos_data_valid = valid_q;
  assign bus.cap_busy        = (state != ST_IDLE);
  assign bus.cap_err         = err_q;

endmodule

`default_nettype wire

// File: tb/tb_cmos_capture_16b.sv
// tb_cmos_capture_16b: directed frame scenarios with random pixel bytes against a frame-level word model.
// Rev 1.0
`default_nettype none

module tb_cmos_capture_16b;
  localparam int IMG_ROW     = 8;
  localparam int IMG_COL     = 512;
  localparam int SKIP_FRAMES = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cmos_capture_16b_if bus();

  cmos_capture_16b #(
    .IMG_ROW(IMG_ROW),
    .IMG_COL(IMG_COL),
    .SKIP_FRAMES(SKIP_FRAMES)
  ) dut (
    .cmos_pclk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor-owned observations.
  logic [15:0] got_q[$];
  int          en_cyc_q[$];
  int          vrise_q[$];
  int          vfall_q[$];
  int          consec     = 0;
  int          en_outside = 0;
  logic        prev_en    = 1'b0;
  logic        prev_valid = 1'b0;

  always @(negedge clk) begin
    if (bus.data_16b_en === 1'b1) begin
      got_q.push_back(bus.data_16b);
      en_cyc_q.push_back(cyc);
      if (prev_en) consec = consec + 1;
      if (bus.cmos_data_valid !== 1'b1) en_outside = en_outside + 1;
    end
    if ((bus.cmos_data_valid === 1'b1) && !prev_valid) vrise_q.push_back(cyc);
    if ((bus.cmos_data_valid !== 1'b1) && prev_valid) vfall_q.push_back(cyc);
    prev_en    = (bus.data_16b_en === 1'b1);
    prev_valid = (bus.cmos_data_valid === 1'b1);
  end

  // Main-owned model state.
  logic [15:0] exp_q[$];
  logic        exp_err;
  int          vs_fall_cyc;
  int          sb_cyc;
  int          base_got, base_vr, base_vf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 200 && bus.cap_busy !== 1'b0; i++) @(negedge clk);
    check(tag, {31'd0, bus.cap_busy}, 32'd0);
  endtask

  task automatic pulse_start();
    @(negedge clk); bus.capture_start = 1'b1;
    @(negedge clk); bus.capture_start = 1'b0;
  endtask

  task automatic begin_capture();
    exp_q.delete();
    exp_err  = 1'b0;
    base_got = got_q.size();
    base_vr  = vrise_q.size();
    base_vf  = vfall_q.size();
  endtask

  task automatic check_words(input string tag);
    int nm = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      if ((base_got + i >= got_q.size()) || (got_q[base_got + i] !== exp_q[i])) nm++;
    end
    check(tag, nm, 0);
  endtask

  // One vsync pulse followed by nlines lines; rec marks the frame the DUT is expected to capture.
  task automatic send_frame(input int nlines, input int long_line, input bit rec,
                            input int start_line, input int rst_line);
    logic [7:0] hi, b;
    int nbytes;
    repeat (4) begin @(negedge clk); bus.cmos_vsync = 1'b1; end
    @(negedge clk); bus.cmos_vsync = 1'b0;
    if (rec) vs_fall_cyc = cyc;
    repeat (10) @(negedge clk);
    if (rec && ((nlines < IMG_ROW) || (long_line >= 0 && long_line < nlines))) exp_err = 1'b1;
    hi = 8'd0;
    for (int l = 0; l < nlines; l++) begin
      nbytes = 2 * IMG_COL + ((l == long_line) ? 2 : 0);
      for (int k = 0; k < nbytes; k++) begin
        @(negedge clk);
        if (rec && l == 0 && k == 0)      b = 8'h12;
        else if (rec && l == 0 && k == 1) b = 8'h34;
        else                              b = 8'($urandom);
        bus.cmos_href = 1'b1;
        bus.cmos_data = b;
        if (k % 2 == 0) begin
          hi = b;
        end else if (rec && (k / 2) < IMG_COL) begin
`ifdef CAPTURE_TEST_PATTERN_EN
          exp_q.push_back({8'(l), 8'(k / 2)});
`else
          exp_q.push_back({hi, b});
`endif
          if (l == 0 && k == 1) sb_cyc = cyc;
        end
        if (l == rst_line && k == 300) begin
          rst = 1'b1;
          @(negedge clk);
          rst = 1'b0;
          bus.cmos_href = 1'b0;
          check("rst_mid_data",  {16'd0, bus.data_16b}, 32'd0);
          check("rst_mid_en",    {31'd0, bus.data_16b_en}, 32'd0);
          check("rst_mid_valid", {31'd0, bus.cmos_data_valid}, 32'd0);
          check("rst_mid_busy",  {31'd0, bus.cap_busy}, 32'd0);
          check("rst_mid_err",   {31'd0, bus.cap_err}, 32'd0);
          repeat (10) @(negedge clk);
          return;
        end
      end
      @(negedge clk); bus.cmos_href = 1'b0; bus.cmos_data = 8'd0;
      if (l == start_line) begin
        bus.capture_start = 1'b1;
        @(negedge clk); bus.capture_start = 1'b0;
      end
      repeat (5) @(negedge clk);
    end
    repeat (10) @(negedge clk);
  endtask

  initial begin
    #1500000;
    $display("FAIL global_timeout observed=%0d expected=finish", cyc);
    $fatal(1, "simulation time limit");
  end

  initial begin
    rst = 1'b1;
    bus.capture_start = 1'b0;
    bus.cmos_vsync    = 1'b0;
    bus.cmos_href     = 1'b0;
    bus.cmos_data     = 8'd0;
    exp_err = 1'b0;
    vs_fall_cyc = 0;
    sb_cyc = 0;
    repeat (3) @(negedge clk);
    check("reset_data",  {16'd0, bus.data_16b}, 32'd0);
    check("reset_en",    {31'd0, bus.data_16b_en}, 32'd0);
    check("reset_valid", {31'd0, bus.cmos_data_valid}, 32'd0);
    check("reset_busy",  {31'd0, bus.cap_busy}, 32'd0);
    check("reset_err",   {31'd0, bus.cap_err}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Clean capture after two full settling frames; a second start mid-frame must be ignored.
    begin_capture();
    pulse_start();
    check("t1_busy_after_start", {31'd0, bus.cap_busy}, 32'd1);
    send_frame(IMG_ROW, -1, 1'b0, -1, -1);
    send_frame(IMG_ROW, -1, 1'b0, -1, -1);
    check("t1_no_words_in_skip", got_q.size() - base_got, 0);
    send_frame(IMG_ROW, -1, 1'b1, 2, -1);
    wait_idle("t1_idle");
    check("t1_count", got_q.size() - base_got, IMG_ROW * IMG_COL);
    check_words("t1_words");
`ifdef CAPTURE_TEST_PATTERN_EN
    check("t1_tp_l2w5", {16'd0, got_q[base_got + 2 * IMG_COL + 5]}, 32'h0205);
    check("t1_tp_last", {16'd0, got_q[got_q.size() - 1]}, 32'h07FF);
`else
    check("t1_first", {16'd0, got_q[base_got]}, 32'h1234);
`endif
    check("t1_err", {31'd0, bus.cap_err}, {31'd0, exp_err});
    check("t1_valid_windows", vrise_q.size() - base_vr, 1);
    check("t1_valid_rise_lat", vrise_q[base_vr] - vs_fall_cyc, 3);
    check("t1_data_lat", en_cyc_q[base_got] - sb_cyc, 2);
    check("t1_valid_fall_lat", vfall_q[base_vf] - en_cyc_q[en_cyc_q.size() - 1], 2);
    check("t1_en_consecutive", consec, 0);
    check("t1_en_outside_valid", en_outside, 0);

    // Line 3 carries one extra word: dropped, error sticks until the next start.
    begin_capture();
    pulse_start();
    send_frame(0, -1, 1'b0, -1, -1);
    send_frame(0, -1, 1'b0, -1, -1);
    send_frame(IMG_ROW, 3, 1'b1, -1, -1);
    wait_idle("t2_idle");
    check("t2_count", got_q.size() - base_got, IMG_ROW * IMG_COL);
    check_words("t2_words");
    check("t2_err", {31'd0, bus.cap_err}, {31'd0, exp_err});
    send_frame(0, -1, 1'b0, -1, -1);
    check("t2_err_sticky", {31'd0, bus.cap_err}, 32'd1);

    // Short frame: vsync after five lines ends the capture with an error.
    begin_capture();
    pulse_start();
    check("t3_err_cleared", {31'd0, bus.cap_err}, 32'd0);
    send_frame(0, -1, 1'b0, -1, -1);
    send_frame(0, -1, 1'b0, -1, -1);
    send_frame(5, -1, 1'b1, -1, -1);
    send_frame(0, -1, 1'b0, -1, -1);
    wait_idle("t3_idle");
    check("t3_count", got_q.size() - base_got, 5 * IMG_COL);
    check_words("t3_words");
    check("t3_err", {31'd0, bus.cap_err}, {31'd0, exp_err});
    check("t3_valid_closed", vfall_q.size() - base_vf, 1);

    // Reset in the middle of line 4, then a fresh clean capture.
    begin_capture();
    pulse_start();
    send_frame(0, -1, 1'b0, -1, -1);
    send_frame(0, -1, 1'b0, -1, -1);
    send_frame(IMG_ROW, -1, 1'b0, -1, 4);
    check("t4_idle_after_rst", {31'd0, bus.cap_busy}, 32'd0);
    begin_capture();
    pulse_start();
    send_frame(0, -1, 1'b0, -1, -1);
    send_frame(0, -1, 1'b0, -1, -1);
    send_frame(IMG_ROW, -1, 1'b1, -1, -1);
    wait_idle("t4_idle");
    check("t4_count", got_q.size() - base_got, IMG_ROW * IMG_COL);
    check_words("t4_words");
    check("t4_err", {31'd0, bus.cap_err}, {31'd0, exp_err});
    check("final_en_consecutive", consec, 0);
    check("final_en_outside_valid", en_outside, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

`default_nettype wire
